// File: rtl/mandel_engine.sv
// rtl/mandel_engine.sv - escape-time fractal pixel engine (Mandelbrot/Julia) with ready/valid result port
module mandel_engine #(
  parameter int DATA_W   = 18,
  parameter int FRAC_W   = 14,
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int MAX_ITER = 150,
  parameter int ITER_W   = 12,
  parameter int ADDR_W   = 19
) (
  input  logic                     i_clk_100m,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_continuous,
  input  logic                     i_julia_mode,
  input  logic signed [DATA_W-1:0] i_re_start,
  input  logic signed [DATA_W-1:0] i_im_start,
  input  logic signed [DATA_W-1:0] i_step,
  input  logic signed [DATA_W-1:0] i_julia_re,
  input  logic signed [DATA_W-1:0] i_julia_im,
  output logic                     o_wr_valid,
  input  logic                     i_wr_ready,
  output logic [ADDR_W-1:0]        o_wr_addr,
  output logic [ITER_W-1:0]        o_wr_iter,
  output logic                     o_wr_in_set,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int X_W = $clog2(H_RES + 1);
  localparam int Y_W = $clog2(V_RES + 1);
  localparam logic [DATA_W:0]              ESC_LIM  = (DATA_W + 1)'(4) << FRAC_W;
  localparam logic signed [DATA_W-1:0]     SAT_MAX  = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0]   SQ_LIM   = (2 * DATA_W)'(1) << (FRAC_W + DATA_W - 1);
  localparam logic [ITER_W-1:0]            ITER_MAX = ITER_W'(MAX_ITER);
  localparam logic [X_W-1:0]               X_LAST   = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]               Y_LAST   = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_WRITE} state_t;

  state_t r_state, w_next;

  logic signed [DATA_W-1:0] r_sh_re, r_sh_step, r_sh_jr, r_sh_ji;
  logic                     r_sh_jm;
  logic signed [DATA_W-1:0] r_pr, r_pi, r_cr, r_ci, r_zr, r_zi;
  logic [ITER_W-1:0]        r_iter, r_wr_iter;
  logic [X_W-1:0]           r_x;
  logic [Y_W-1:0]           r_y;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_wr_in_set, r_frame_done;

  logic signed [2*DATA_W-1:0] w_rr_full, w_ii_full, w_ri_full;
  logic signed [DATA_W-1:0]   w_rr, w_ii, w_zr_next, w_zi_next;
  logic [DATA_W:0]            w_mag;
  logic w_done, w_accept, w_last_x, w_last, w_frame_start;

  // Squares are non-negative, so the only overflow is above the positive range: clamp there.
  assign w_rr_full = r_zr * r_zr;
  assign w_ii_full = r_zi * r_zi;
  assign w_ri_full = r_zr * r_zi;
  assign w_rr      = (w_rr_full >= SQ_LIM) ? SAT_MAX : DATA_W'(w_rr_full >>> FRAC_W);
  assign w_ii      = (w_ii_full >= SQ_LIM) ? SAT_MAX : DATA_W'(w_ii_full >>> FRAC_W);
  assign w_mag     = {1'b0, w_rr} + {1'b0, w_ii};
  assign w_zi_next = DATA_W'(w_ri_full >>> (FRAC_W - 1)) + r_ci;
  assign w_zr_next = w_rr - w_ii + r_cr;
  assign w_done    = (w_mag > ESC_LIM) || (r_iter == ITER_MAX);

  assign w_accept      = (r_state == S_WRITE) && i_wr_ready;
  assign w_last_x      = (r_x == X_LAST);
  assign w_last        = w_last_x && (r_y == Y_LAST);
  assign w_frame_start = ((r_state == S_IDLE) && i_start) || (w_accept && w_last && i_continuous);

  always_ff @(posedge i_clk_100m) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  w_next = S_ITER;
      S_ITER:  if (w_done) w_next = S_WRITE;
      S_WRITE: if (i_wr_ready) w_next = (w_last && !i_continuous) ? S_IDLE : S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_100m) begin
    if (i_rst) begin
      r_sh_re <= '0; r_sh_step <= '0; r_sh_jr <= '0; r_sh_ji <= '0; r_sh_jm <= 1'b0;
      r_pr <= '0; r_pi <= '0; r_cr <= '0; r_ci <= '0; r_zr <= '0; r_zi <= '0;
      r_iter <= '0; r_wr_iter <= '0; r_wr_in_set <= 1'b0; r_frame_done <= 1'b0;
      r_x <= '0; r_y <= '0; r_addr <= '0;
    end else begin
      r_frame_done <= w_accept && w_last;
      if (w_frame_start) begin
        r_sh_re   <= i_re_start;
        r_sh_step <= i_step;
        r_sh_jr   <= i_julia_re;
        r_sh_ji   <= i_julia_im;
        r_sh_jm   <= i_julia_mode;
        r_pr      <= i_re_start;
        r_pi      <= i_im_start;
        r_x       <= '0;
        r_y       <= '0;
        r_addr    <= '0;
      end else if (w_accept) begin
        r_addr <= r_addr + 1'b1;
        if (w_last_x) begin
          r_x  <= '0;
          r_y  <= r_y + 1'b1;
          r_pr <= r_sh_re;
          r_pi <= r_pi - r_sh_step;
        end else begin
          r_x  <= r_x + 1'b1;
          r_pr <= r_pr + r_sh_step;
        end
      end

      // The first orbit point is C itself, so iteration starts at 1 with Z already at the pixel.
      if (r_state == S_LOAD) begin
        r_cr   <= r_sh_jm ? r_sh_jr : r_pr;
        r_ci   <= r_sh_jm ? r_sh_ji : r_pi;
        r_zr   <= r_pr;
        r_zi   <= r_pi;
        r_iter <= ITER_W'(1);
      end else if (r_state == S_ITER) begin
        if (w_done) begin
          r_wr_in_set <= (r_iter == ITER_MAX);
          r_wr_iter   <= (r_iter == ITER_MAX) ? '0 : r_iter;
        end else begin
          r_zr   <= w_zr_next;
          r_zi   <= w_zi_next;
          r_iter <= r_iter + 1'b1;
        end
      end
    end
  end

  assign o_wr_valid   = (r_state == S_WRITE);
  assign o_wr_addr    = r_addr;
  assign o_wr_iter    = r_wr_iter;
  assign o_wr_in_set  = r_wr_in_set;
  assign o_busy       = (r_state != S_IDLE);
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_mandel_engine.sv
// tb/tb_mandel_engine.sv - randomized self-checking bench for mandel_engine on a 4x4 raster
module tb_mandel_engine;
  localparam int H = 4;
  localparam int V = 4;
  localparam int NPIX = H * V;
  localparam int MAXI = 150;

  logic clk = 1'b0;
  logic rst, start, continuous, julia_mode, wr_ready;
  logic signed [17:0] re_start, im_start, step, julia_re, julia_im;
  logic wr_valid, wr_in_set, busy, frame_done;
  logic [18:0] wr_addr;
  logic [11:0] wr_iter;

  logic signed [17:0] s_re, s_im, s_st, s_jr, s_ji;
  logic s_jm;
  int n_checks = 0;
  int n_errs = 0;
  int fd_seen;

  always #5 clk = ~clk;

  mandel_engine #(
    .DATA_W(18), .FRAC_W(14), .H_RES(H), .V_RES(V),
    .MAX_ITER(MAXI), .ITER_W(12), .ADDR_W(19)
  ) u_dut (
    .i_clk_100m(clk), .i_rst(rst), .i_start(start), .i_continuous(continuous),
    .i_julia_mode(julia_mode), .i_re_start(re_start), .i_im_start(im_start),
    .i_step(step), .i_julia_re(julia_re), .i_julia_im(julia_im),
    .o_wr_valid(wr_valid), .i_wr_ready(wr_ready), .o_wr_addr(wr_addr),
    .o_wr_iter(wr_iter), .o_wr_in_set(wr_in_set), .o_busy(busy),
    .o_frame_done(frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap18(input longint v);
    logic signed [17:0] t;
    t = v[17:0];
    return longint'(t);
  endfunction

  function automatic longint sq_sat(input longint a);
    longint p;
    p = (a * a) >>> 14;
    return (p > 131071) ? 131071 : p;
  endfunction

  // Escape count from the fixed-point rules: first orbit point is C, escape when |Z|^2 > 4.0.
  function automatic int ref_iter(input longint cr, input longint ci, input longint zr0, input longint zi0);
    longint zr, zi, rr, ii, t;
    zr = zr0;
    zi = zi0;
    for (int it = 1; it <= MAXI; it++) begin
      rr = sq_sat(zr);
      ii = sq_sat(zi);
      if (rr + ii > 65536 || it == MAXI) return it;
      t  = wrap18(wrap18((2 * zr * zi) >>> 14) + ci);
      zr = wrap18(rr - ii + cr);
      zi = t;
    end
    return MAXI;
  endfunction

  function automatic int ref_pixel(input int p);
    longint pr, pi;
    pr = wrap18(longint'(s_re) + longint'(p % H) * longint'(s_st));
    pi = wrap18(longint'(s_im) - longint'(p / H) * longint'(s_st));
    if (s_jm) return ref_iter(longint'(s_jr), longint'(s_ji), pr, pi);
    return ref_iter(pr, pi, pr, pi);
  endfunction

  task automatic set_params(input int re, input int im, input int st, input int jr, input int ji, input logic jm);
    re_start = 18'(re); im_start = 18'(im); step = 18'(st);
    julia_re = 18'(jr); julia_im = 18'(ji); julia_mode = jm;
    s_re = 18'(re); s_im = 18'(im); s_st = 18'(st); s_jr = 18'(jr); s_ji = 18'(ji); s_jm = jm;
  endtask

  // Follows one frame; stray start pulses are injected while busy and must be ignored.
  task automatic run_frame(input bit do_start, input int rdy_pct, input int hold_pix,
                           input bit change_re, input int new_re, output int first_cyc);
    int pix, cyc, k;
    bit held;
    logic [31:0] sa, si, ss;
    pix = 0; cyc = 0; held = 1'b0; first_cyc = -1; fd_seen = 0;
    if (do_start) start = 1'b1;
    while (pix < NPIX && cyc < 20000) begin
      @(posedge clk); #1;
      start = (cyc > 0) && ($urandom_range(7) == 0);
      wr_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      cyc++;
      if (frame_done) fd_seen++;
      if (wr_valid) begin
        if (first_cyc < 0) first_cyc = cyc - 1;
        if (!held && pix == hold_pix) begin
          held = 1'b1;
          sa = 32'(wr_addr); si = 32'(wr_iter); ss = 32'(wr_in_set);
          wr_ready = 1'b0;
          repeat (20) begin
            @(posedge clk); #1;
            @(negedge clk);
            cyc++;
            check_val("hold_valid", 32'(wr_valid), 1);
            check_val("hold_addr", 32'(wr_addr), sa);
            check_val("hold_iter", 32'(wr_iter), si);
            check_val("hold_in_set", 32'(wr_in_set), ss);
          end
          wr_ready = 1'b1;
        end
        if (wr_ready) begin
          k = ref_pixel(pix);
          check_val("wr_addr", 32'(wr_addr), pix);
          check_val("wr_in_set", 32'(wr_in_set), (k == MAXI) ? 1 : 0);
          check_val("wr_iter", 32'(wr_iter), (k == MAXI) ? 0 : k);
          pix++;
          if (change_re && pix == 3) re_start = 18'(new_re);
        end
      end
    end
    start = 1'b0;
    check_val("frame_timeout_pixels", pix, NPIX);
    check_val("frame_done_early", fd_seen, 0);
    @(negedge clk);
    check_val("frame_done_pulse", 32'(frame_done), 1);
    check_val("busy_after_frame", 32'(busy), 32'(continuous));
  endtask

  int fc, nval;

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; wr_ready = 1'b1;
    set_params(0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_valid", 32'(wr_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_frame_done", 32'(frame_done), 0);
    check_val("rst_addr", 32'(wr_addr), 0);
    check_val("rst_iter", 32'(wr_iter), 0);
    check_val("rst_in_set", 32'(wr_in_set), 0);

    // Reset while iterating an in-set pixel discards it
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_val("midrst_valid", 32'(wr_valid), 0);
    check_val("midrst_busy", 32'(busy), 0);
    nval = 0;
    repeat (200) begin
      @(negedge clk);
      if (wr_valid || busy) nval++;
    end
    check_val("midrst_no_writes", nval, 0);

    // -3.0 + step 0.25: every pixel escapes immediately
    set_params(-49152, 0, 4096, 0, 0, 1'b0);
    run_frame(1'b1, 100, -1, 1'b0, 0, fc);
    check_val("fast_first_latency", fc, 2);

    // C = 0: in set, first result after 1 + MAX_ITER cycles
    set_params(0, 0, 0, 0, 0, 1'b0);
    run_frame(1'b1, 100, -1, 1'b0, 0, fc);
    check_val("inset_latency", fc, 1 + MAXI);

    // C = -2.0 sits exactly on |Z|^2 = 4.0
    set_params(-32768, 0, 0, 0, 0, 1'b0);
    run_frame(1'b1, 100, -1, 1'b0, 0, fc);

    // C = 0.5: escapes after several iterations
    set_params(8192, 0, 0, 0, 0, 1'b0);
    run_frame(1'b1, 100, -1, 1'b0, 0, fc);

    // 7.9: square saturates and must still escape
    set_params(129434, 0, 0, 0, 0, 1'b0);
    run_frame(1'b1, 100, -1, 1'b0, 0, fc);

    // Backpressure with a 20-cycle stall on pixel 5
    set_params(-24576, 16384, 4096, 0, 0, 1'b0);
    run_frame(1'b1, 50, 5, 1'b0, 0, fc);

    // Continuous: re_start changed mid-frame only takes effect in the next frame
    continuous = 1'b1;
    set_params(-49152, 8192, 2048, 0, 0, 1'b0);
    run_frame(1'b1, 100, -1, 1'b1, -16384, fc);
    continuous = 1'b0;
    s_re = -18'sd16384;
    run_frame(1'b0, 100, -1, 1'b0, 0, fc);
    check_val("idle_after_continuous", 32'(busy), 0);

    // Julia c = (-0.8, 0.156) over [-1.5, 1.5]
    set_params(-24576, 24576, 16384, -13107, 2556, 1'b1);
    run_frame(1'b1, 100, -1, 1'b0, 0, fc);

    for (int f = 0; f < 4; f++) begin
      set_params(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768,
                 int'($urandom_range(8191)) - 4096, int'($urandom_range(32767)) - 16384,
                 int'($urandom_range(32767)) - 16384, 1'($urandom_range(1)));
      run_frame(1'b1, 70, int'($urandom_range(NPIX - 1)), 1'b0, 0, fc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/mandel_engine.md
Name: mandel_engine

Overview:
- Parametrised fractal pixel engine; the next generation of the fixed 640x480, 18-bit escape-time generator.
- Walks a configurable raster and iterates Z(n+1) = Z(n)^2 + C per pixel in signed fixed point, then writes one result per pixel to the frame RAM through a ready/valid write port.
- Adds three features the previous generator lacks:
  - Julia mode.
  - Overflow-safe escape test.
  - Frame-boundary parameter latching for glitch-free pan/zoom, with single-shot or continuous frames.
- Sits between the button/zoom controller (supplies view parameters) and the frame-RAM/colour mapper.

Parameters:
DATA_W, 18, total fixed-point width (sign + integer + fraction)
FRAC_W, 14, fractional bits
H_RES, 640, pixels per row
V_RES, 480, rows per frame
MAX_ITER, 150, iteration limit; a pixel reaching it is "in set"
ITER_W, 12, iteration counter / result width (2^ITER_W > MAX_ITER)
ADDR_W, 19, write address width (2^ADDR_W >= H_RES*V_RES)

Ports:
Clk_100M  in  1  system clock
Rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
continuous  in  1  1 = restart automatically after the last pixel
julia_mode  in  1  0 = Mandelbrot, 1 = Julia; latched at frame start
re_start  in  DATA_W  signed real coordinate of pixel (0,0)
im_start  in  DATA_W  signed imaginary coordinate of pixel (0,0)
step  in  DATA_W  signed per-pixel increment (real +, imaginary −)
julia_re  in  DATA_W  Julia constant, real part
julia_im  in  DATA_W  Julia constant, imaginary part
wr_valid  out  1  result valid
wr_ready  in  1  RAM accepts result
wr_addr  out  ADDR_W  pixel index y*H_RES + x
wr_iter  out  ITER_W  escape iteration count (0 when in set)
wr_in_set  out  1  pixel reached MAX_ITER
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
Reset and start:
- Reset (any state, mid-frame included): state = IDLE; wr_valid = busy = frame_done = wr_in_set = 0; wr_addr = wr_iter = 0. Any in-flight pixel is discarded.
- Frame start, either start in IDLE or a continuous wrap:
  - Latch re_start, im_start, step, julia_re, julia_im, julia_mode into shadow registers.
  - Inputs changing mid-frame have no effect until the next frame start.
  - x = y = 0, addr = 0, pixel coordinate (pr, pi) = (re_start, im_start).
- start while busy = 1: ignored.

States:
- IDLE: busy = 0. On start → LOAD.
- LOAD, 1 cycle, busy = 1:
  - Mandelbrot: C = (pr, pi), Z = (pr, pi).
  - Julia: C = (julia_re, julia_im), Z = (pr, pi).
  - iter = 1, since f(0) = C is skipped. → ITER.
- ITER, one iteration per cycle:
  - rr = Zr*Zr and ii = Zi*Zi as full 2*DATA_W products, rescaled by taking bits [FRAC_W+DATA_W-1:FRAC_W]. Saturate to the maximum positive DATA_W value if the product exceeds the range.
  - mag = rr + ii, computed at DATA_W+1 bits with no wrap.
  - If mag > 4.0 or iter == MAX_ITER → WRITE.
  - Otherwise:
    - Zi ← (2*Zr*Zi rescaled, wrapping) + Ci.
    - Zr ← rr − ii + Cr.
    - iter ← iter + 1.
- WRITE:
  - wr_valid = 1; wr_addr = addr.
  - In set (iter == MAX_ITER): wr_in_set = 1, wr_iter = 0. Otherwise wr_in_set = 0, wr_iter = iter.
  - wr_addr, wr_iter and wr_in_set are held stable while wr_ready = 0.
  - When wr_valid & wr_ready, advance in the same cycle:
    - If x == H_RES−1 and y == V_RES−1: pulse frame_done next cycle. If continuous, perform a frame start → LOAD; else → IDLE.
    - Else if x == H_RES−1: x = 0, y + 1, pr = re_start(shadow), pi = pi − step, addr + 1 → LOAD.
    - Else: x + 1, pr = pr + step, addr + 1 → LOAD.
- wr_valid deasserts the cycle after acceptance.

Latency and ordering:
- Pixel latency = 1 (LOAD) + k (ITER) + n (WRITE, n ≥ 1 acceptance cycles).
- k = escape iteration count; k = MAX_ITER for in-set pixels.
- Addresses are strictly sequential 0 … H_RES*V_RES−1 with no gaps or repeats.

Test Plan:
- Reset mid-ITER with wr_ready = 1 → next cycle wr_valid = 0, busy = 0, no further writes until start.
- H_RES = 4, V_RES = 2, re_start = −3.0, step = 0.25, im_start = 0, wr_ready = 1, start → 8 writes, addr 0..7, each wr_iter = 1 (|C| > 2), frame_done pulses once after addr 7, busy falls.
- Single pixel C = 0 (H_RES = V_RES = 1, step = 0) → wr_in_set = 1, wr_iter = 0, wr_valid rises exactly 1 + 150 cycles after LOAD entry.
- C = −2.0 + 0i → never exceeds 4.0 (stays at 4) → in set; C = 0.5 + 0i → escapes with a wr_iter matching the golden model; Zr = 7.9 on the test hook → saturation, escape flagged, no wrap to negative.
- Hold wr_ready = 0 for 20 cycles during WRITE → outputs stable, exactly one accept, next addr = previous + 1.
- continuous = 1, change re_start mid-frame → current frame uses the old value, the next frame's pixel 0 uses the new value; Julia mode with julia = (−0.8, 0.156) matches the golden model for a 4x4 raster.
